// File: rtl/msrv32_pkg.sv
// Shared constants for the msrv32 front end: canonical NOP,
// major opcodes and instruction field bit positions.
package msrv32_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;
  localparam int CSR_LSB    = 20;
  localparam int BODY_LSB   = 7;

endpackage

// File: rtl/msrv32_instr_field_split.sv
// Combinational split of a 32-bit instruction word into
// the decode fields consumed by the decode stage.
module msrv32_instr_field_split
  import msrv32_pkg::*;
(
  input  logic [31:0] word_in,
  output logic [6:0]  opcode_out,
  output logic [2:0]  funct3_out,
  output logic [6:0]  funct7_out,
  output logic [4:0]  rs1addr_out,
  output logic [4:0]  rs2addr_out,
  output logic [4:0]  rdaddr_out,
  output logic [11:0] csr_addr_out,
  output logic [24:0] instr_out
);

  assign opcode_out   = word_in[OPCODE_LSB +: 7];
  assign funct3_out   = word_in[FUNCT3_LSB +: 3];
  assign funct7_out   = word_in[FUNCT7_LSB +: 7];
  assign rs1addr_out  = word_in[RS1_LSB +: 5];
  assign rs2addr_out  = word_in[RS2_LSB +: 5];
  assign rdaddr_out   = word_in[RD_LSB +: 5];
  assign csr_addr_out = word_in[CSR_LSB +: 12];
  assign instr_out    = word_in[BODY_LSB +: 25];

endmodule

// File: rtl/msrv32_instr_fetch_queue.sv
// Instruction buffer between fetch and decode; an empty or
// flushing queue presents the canonical NOP at the head.
module msrv32_instr_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = msrv32_pkg::NOP_INSTR,
  parameter int unsigned PC_W      = 32,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic            ms_riscv32_mp_clk_in,
  input  logic            ms_riscv32_mp_rst_n_in,
  input  logic [31:0]     ms_riscv32_mp_instr_in,
  input  logic [PC_W-1:0] pc_in,
  input  logic            instr_valid_in,
  output logic            instr_ready_out,
  input  logic            flush_in,
  input  logic            stall_in,
  output logic            valid_out,
  output logic [PC_W-1:0] pc_out,
  output logic [6:0]      opcode_out,
  output logic [2:0]      funct3_out,
  output logic [6:0]      funct7_out,
  output logic [4:0]      rs1addr_out,
  output logic [4:0]      rs2addr_out,
  output logic [4:0]      rdaddr_out,
  output logic [11:0]     csr_addr_out,
  output logic [24:0]     instr_out,
  output logic [CW-1:0]   count_out
);

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [PC_W-1:0] pc_mem_q [DEPTH];
  logic            push, pop;
  logic [31:0]     head_word;

  assign instr_ready_out = (count_q != CW'(DEPTH));
  assign valid_out = (count_q != '0) & ~flush_in;
  assign push = instr_valid_in & instr_ready_out & ~flush_in;
  assign pop  = valid_out & ~stall_in;
  assign count_out = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_in) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; valid_out masks stale slots.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= ms_riscv32_mp_instr_in;
      pc_mem_q[wr_ptr_q]    <= pc_in;
    end
  end

  assign head_word = valid_out ? instr_mem_q[rd_ptr_q] : NOP_INSTR;
  assign pc_out    = valid_out ? pc_mem_q[rd_ptr_q] : '0;

  msrv32_instr_field_split u_split (
    .word_in      (head_word),
    .opcode_out   (opcode_out),
    .funct3_out   (funct3_out),
    .funct7_out   (funct7_out),
    .rs1addr_out  (rs1addr_out),
    .rs2addr_out  (rs2addr_out),
    .rdaddr_out   (rdaddr_out),
    .csr_addr_out (csr_addr_out),
    .instr_out    (instr_out)
  );

endmodule

// File: tb/tb_msrv32_instr_fetch_queue.sv
// Scoreboard bench for the fetch queue: driver offers words,
// checker keeps the expected queue and compares every cycle.
module tb_msrv32_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr_in;
  logic [31:0] pc_in;
  logic        instr_valid;
  logic        ready;
  logic        flush;
  logic        stall;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd;
  logic [11:0] csr;
  logic [24:0] body;
  logic [2:0]  count;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic        acc = 1'b0;
  int          total = 0;
  int          bad = 0;
  logic [31:0] cur_pc, cur_w;
  logic [31:0] wl[$];

  always #5 clk = ~clk;

  msrv32_instr_fetch_queue #(.DEPTH(DEPTH)) dut (
    .ms_riscv32_mp_clk_in   (clk),
    .ms_riscv32_mp_rst_n_in (rst_n),
    .ms_riscv32_mp_instr_in (instr_in),
    .pc_in                  (pc_in),
    .instr_valid_in         (instr_valid),
    .instr_ready_out        (ready),
    .flush_in               (flush),
    .stall_in               (stall),
    .valid_out              (valid_out),
    .pc_out                 (pc_out),
    .opcode_out             (opcode),
    .funct3_out             (funct3),
    .funct7_out             (funct7),
    .rs1addr_out            (rs1),
    .rs2addr_out            (rs2),
    .rdaddr_out             (rd),
    .csr_addr_out           (csr),
    .instr_out              (body),
    .count_out              (count)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Checker: compare the head against the expected queue, then
  // apply this cycle's push/pop/flush to the expected queue.
  always begin
    logic        ev, dpop, dpush;
    logic [31:0] ew, epc;
    @(negedge clk);
    #2;
    if (!rst_n) begin
      mq.delete();
      acc = 1'b0;
      chk("rst_count", 64'(count), 0);
      chk("rst_valid", 64'(valid_out), 0);
      chk("rst_ready", 64'(ready), 1);
      chk("rst_word", 64'({body, opcode}), 64'(NOP));
    end else begin
      ev  = (mq.size() != 0) && !flush;
      ew  = ev ? mq[0].w : NOP;
      epc = ev ? mq[0].pc : 32'h0;
      chk("valid", 64'(valid_out), 64'(ev));
      chk("count", 64'(count), 64'(mq.size()));
      chk("ready", 64'(ready), 64'(mq.size() < DEPTH));
      chk("pc", 64'(pc_out), 64'(epc));
      chk("word", 64'({body, opcode}), 64'(ew));
      chk("regs", 64'({funct7, rs2, rs1, funct3, rd}),
          64'({ew[31:25], ew[24:20], ew[19:15], ew[14:12], ew[11:7]}));
      chk("csr", 64'(csr), 64'(ew[31:20]));
      acc = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        dpop  = ev && !stall;
        dpush = instr_valid && (mq.size() < DEPTH);
        if (dpop) void'(mq.pop_front());
        if (dpush) begin
          mq.push_back('{pc: pc_in, w: instr_in});
          acc = 1'b1;
        end
      end
    end
  end

  task automatic step(input logic v, input logic s, input logic f);
    @(negedge clk);
    if (acc) begin
      cur_pc = cur_pc + 32'd4;
      cur_w  = (wl.size() != 0) ? wl.pop_front() : $urandom;
    end
    instr_valid = v;
    stall       = s;
    flush       = f;
    instr_in    = cur_w;
    pc_in       = cur_pc;
    #3;
  endtask

  initial begin
    rst_n = 1'b0;
    instr_valid = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    instr_in = '0;
    pc_in = '0;
    cur_pc = 32'h100;
    cur_w = $urandom;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    // Reset in the middle of traffic with three entries held
    for (int i = 0; i < 20 && mq.size() != 3; i++) step(1, 1, 0);
    chk("t1_fill", 64'(mq.size()), 3);
    #3;
    chk("t1_pre_count", 64'(count), 3);
    instr_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t1_count", 64'(count), 0);
    chk("t1_valid", 64'(valid_out), 0);
    chk("t1_opcode", 64'(opcode), 64'h13);
    chk("t1_rd", 64'(rd), 0);
    chk("t1_ready", 64'(ready), 1);
    @(negedge clk);
    #3 rst_n = 1'b1;

    // Fill to full under stall
    cur_pc = 32'h0;
    wl = '{32'h00500093, 32'h00A00113, 32'h002081B3,
           32'h00000073, 32'h00001117};
    cur_w = wl.pop_front();
    repeat (4) step(1, 1, 0);
    #3;
    chk("t2_count", 64'(count), 4);
    chk("t2_ready", 64'(ready), 0);
    chk("t2_opcode", 64'(opcode), 64'h13);
    chk("t2_rd", 64'(rd), 1);
    chk("t2_pc", 64'(pc_out), 0);

    // Drain from full while offering a fifth word
    step(1, 0, 0);
    chk("t3_ready", 64'(ready), 0);
    for (int i = 0; i < 20 && !(mq.size() == 0 && cur_pc >= 32'h14); i++)
      step(cur_pc < 32'h14, 1'b0, 1'b0);
    chk("t3_drained", 64'(mq.size()), 0);

    // Steady push and pop at occupancy two
    for (int i = 0; i < 10 && mq.size() != 2; i++) step(1, 1, 0);
    repeat (8) step(1, 0, 0);
    #3;
    chk("t4_count", 64'(count), 2);

    // Flush with a valid push and stall at occupancy three
    for (int i = 0; i < 10 && mq.size() != 3; i++) step(1, 1, 0);
    step(1, 1, 1);
    chk("t5_valid", 64'(valid_out), 0);
    chk("t5_opcode", 64'(opcode), 64'h13);
    chk("t5_rd", 64'(rd), 0);

    // Redirected stream starts right after the flush
    cur_pc = 32'h200;
    cur_w  = 32'h0040006F;
    step(1, 0, 0);
    chk("t6_count", 64'(count), 0);
    chk("t6_valid0", 64'(valid_out), 0);
    step(0, 1, 0);
    chk("t6_valid", 64'(valid_out), 1);
    chk("t6_opcode", 64'(opcode), 64'h6F);
    chk("t6_rd", 64'(rd), 0);
    chk("t6_pc", 64'(pc_out), 64'h200);

    // Random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, ($urandom % 3) == 0, ($urandom % 20) == 0);
    repeat (8) step(0, 0, 0);
    chk("final_empty", 64'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
